// File: rtl/md_pkg.sv
// Shared types and constants for the multiply/divide unit controller.
package md_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MFHI  = 4'd5,
    MFLO  = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic is_launch_op(input logic [3:0] op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the next {HI, LO} pair.
module md_arith
  import md_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic        [31:0] q_u;
  logic        [31:0] r_u;

  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    q_s    = '0;
    r_s    = '0;
    q_u    = '0;
    r_u    = '0;
    if (b != 32'd0) begin
      q_u = a / b;
      r_u = a % b;
      // The most-negative / -1 quotient does not fit; it wraps to itself with zero remainder.
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q_s = 32'sh8000_0000;
        r_s = 32'sd0;
      end else begin
        q_s = $signed(a) / $signed(b);
        r_s = $signed(a) % $signed(b);
      end
    end

    res_hi = hi_in;
    res_lo = lo_in;
    case (op)
      MULT:  {res_hi, res_lo} = prod_s;
      MULTU: {res_hi, res_lo} = prod_u;
      DIV: begin
        if (b != 32'd0) begin
          res_hi = r_s;
          res_lo = q_s;
        end
      end
      DIVU: begin
        if (b != 32'd0) begin
          res_hi = r_u;
          res_lo = q_u;
        end
      end
      default: begin
        res_hi = hi_in;
        res_lo = lo_in;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: sequences fixed-latency ops, owns HI/LO,
// and requests D-stage stalls while occupied.
module mdu_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op_e,
  input  logic [31:0] rs_val_e,
  input  logic [31:0] rt_val_e,
  input  logic [3:0]  md_op_d,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        pend_hi_q, pend_hi_d;
  logic [31:0]        pend_lo_q, pend_lo_d;
  logic [31:0]        arith_hi;
  logic [31:0]        arith_lo;
  logic               launch_e;

  md_arith u_arith (
    .op     (md_op_e),
    .a      (rs_val_e),
    .b      (rt_val_e),
    .hi_in  (hi_q),
    .lo_in  (lo_q),
    .res_hi (arith_hi),
    .res_lo (arith_lo)
  );

  assign launch_e = is_launch_op(md_op_e);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // The result is computed at launch; RUN only counts down the latency before committing it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (launch_e) begin
          state_d   = RUN;
          pend_hi_d = arith_hi;
          pend_lo_d = arith_lo;
          cnt_d     = (md_op_e == MULT || md_op_e == MULTU) ? MULT_N : DIV_N;
        end else if (md_op_e == MTHI) begin
          hi_d = rs_val_e;
        end else if (md_op_e == MTLO) begin
          lo_d = rs_val_e;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (md_op_e == MFHI) begin
      rd_data = hi_q;
    end else if (md_op_e == MFLO) begin
      rd_data = lo_q;
    end
  end

  assign busy      = (state_q == RUN);
  assign stall_req = (md_op_d != NONE) && (busy || launch_e);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit controller for the pipelined MIPS core. It sits in the E stage, fed by the decoded opcode/funct fields of the instruction word. It sequences mult/multu/div/divu over a fixed multi-cycle latency, owns the HI/LO registers, and services mfhi/mflo/mthi/mtlo. It raises a stall request so the D stage holds any multiply/divide-class instruction while the unit is occupied.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
md_op_e  input  4  md operation of the instruction in E (encoding in package)
rs_val_e  input  32  operand A / mthi-mtlo source
rt_val_e  input  32  operand B
md_op_d  input  4  md operation of the instruction in D; used only for stall
busy  output  1  multi-cycle operation in progress
stall_req  output  1  D-stage stall request
rd_data  output  32  mfhi/mflo read data
hi  output  32  current HI register
lo  output  32  current LO register

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE, counter=0, busy=0, hi=0, lo=0, pending results=0.
  - Reset during RUN aborts the operation; HI/LO are not written.
- States:
  - IDLE -> RUN when md_op_e is MULT, MULTU, DIV or DIVU.
  - RUN -> IDLE when the counter reaches 1 at an edge.
- Launch edge (IDLE):
  - Compute the result from rs_val_e/rt_val_e and latch it into pending_hi/pending_lo.
  - Load counter = MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter equals 1: hi<=pending_hi, lo<=pending_lo, busy<=0, state<=IDLE.
  - busy is therefore high for exactly N cycles.
  - New HI/LO are visible in the first cycle after busy falls.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi = upper 32 bits, lo = lower 32 bits. MULTU: the same, unsigned.
  - DIV: signed, quotient truncated toward zero into lo; remainder into hi, with the sign of the dividend.
  - DIVU: unsigned.
  - Divisor 0: pending = current hi/lo, so HI/LO stay unchanged; the full DIV_CYCLES busy period still applies.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
- MTHI/MTLO:
  - In IDLE: write rs_val_e at the next edge. No busy.
  - Presented while busy: ignored. The pipeline guarantees this cannot occur via stall_req.
- MFHI/MFLO: rd_data = hi or lo combinationally; otherwise rd_data = 0.
- Any md_op_e other than NONE arriving while busy is ignored: no relaunch, no HI/LO write.
- stall_req = (md_op_d != NONE) && (busy || md_op_e is MULT/MULTU/DIV/DIVU).
  - This covers the launch cycle, before busy rises.
- MTHI in E with MFHI in D: no stall. The write lands at the edge; the D instruction reads the new value when it reaches E.

Decomposition:
- Shared package md_pkg:
  - 4-bit md_op encoding: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - FSM state enum {IDLE, RUN}.
  - Helper constant for counter width (4).
- Sub-module md_arith: purely combinational. It maps op, a, b and current hi/lo to {res_hi, res_lo}, including the div-by-zero and overflow rules above.
- mdu_ctrl keeps the FSM, counter, HI/LO and stall logic.

Test Plan:
- Reset: assert reset for 2 cycles mid-MULT -> busy=0, hi=0, lo=0 the cycle after reset; no later HI/LO update.
- MULT 0xFFFFFFFF x 0x00000002 (md_op_e=MULT for 1 cycle) -> busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV -7 / 2 -> busy 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 7 / 0 with hi=0x11, lo=0x22 beforehand -> busy 10 cycles, hi/lo unchanged.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Stall: MULT in E with MFLO in D -> stall_req=1 in the launch cycle and all 5 busy cycles, 0 after. MFLO read in the following cycle returns the new lo. MTHI 0x1234 in IDLE -> hi=0x1234 next cycle, busy stays 0.
- Back-to-back: DIV launched; a MULT held on md_op_e during busy -> ignored. Re-presenting MULT after busy falls -> new 5-cycle run with correct result.
